// File: rtl/neuron_acc_pkg.sv
// neuron_acc_pkg: shared FSM state type and default parameter values for the
// neuron accumulator.
package neuron_acc_pkg;

   localparam int DEF_OP_W    = 20;
   localparam int DEF_BIAS_W  = 8;
   localparam int DEF_SUM_W   = 22;
   localparam int DEF_N_TERMS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/neuron_acc_add.sv
// neuron_acc_add: signed SUM_W-bit adder. With NEURON_ACC_SAT_EN defined the
// result is clamped to the signed SUM_W range and ovf flags a clamp; without
// it the add wraps modulo 2^SUM_W and ovf is constant 0.
module neuron_acc_add
   import neuron_acc_pkg::*;
#(
   parameter int SUM_W = DEF_SUM_W
) (
   input  logic signed [SUM_W-1:0] a,
   input  logic signed [SUM_W-1:0] b,
   output logic signed [SUM_W-1:0] y,
   output logic                    ovf
);

`ifdef NEURON_ACC_SAT_EN
   localparam logic signed [SUM_W-1:0] MAX_VAL = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_VAL = {1'b1, {(SUM_W-1){1'b0}}};

   // One extra bit catches overflow: the top two bits differ on overflow.
   logic [SUM_W:0] full_sum;
   assign full_sum = {a[SUM_W-1], a} + {b[SUM_W-1], b};

   // Clamp toward the sign of the true (SUM_W+1)-bit result.
   always_comb begin
      y   = full_sum[SUM_W-1:0];
      ovf = 1'b0;
      if (full_sum[SUM_W] != full_sum[SUM_W-1]) begin
         ovf = 1'b1;
         y   = full_sum[SUM_W] ? MIN_VAL : MAX_VAL;
      end
   end
`else
   assign y   = a + b;
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/neuron_acc.sv
// neuron_acc: accumulates N_TERMS signed operands on top of a per-result bias
// and hands the total out through a valid/ready result port. Optional
// saturating arithmetic is enabled with the NEURON_ACC_SAT_EN macro.
module neuron_acc
   import neuron_acc_pkg::*;
#(
   parameter int OP_W    = DEF_OP_W,
   parameter int BIAS_W  = DEF_BIAS_W,
   parameter int SUM_W   = DEF_SUM_W,
   parameter int N_TERMS = DEF_N_TERMS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [BIAS_W-1:0] bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   operand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  sum,
   output logic              sat
);

   localparam int CNT_W = $clog2(N_TERMS + 1);

   state_t                   state_reg;
   logic signed [SUM_W-1:0]  acc_reg;
   logic [CNT_W-1:0]         cnt_reg;
   logic                     sat_acc_reg;
   logic [SUM_W-1:0]         sum_reg;
   logic                     sat_reg;
   logic                     out_valid_reg;

   logic                     in_fire;
   logic                     out_fire;
   logic                     first_term;
   logic                     last_term;
   logic signed [SUM_W-1:0]  bias_ext;
   logic signed [SUM_W-1:0]  op_ext;
   logic signed [SUM_W-1:0]  add_a;
   logic signed [SUM_W-1:0]  add_y;
   logic                     add_ovf;
   logic [CNT_W-1:0]         cnt_next;
   logic                     sat_next;

   // A pending result blocks new operands unless it is leaving this cycle.
   assign in_ready  = (state_reg != DONE) | out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid_reg & out_ready;

   // IDLE and DONE both start a fresh result from the bias.
   assign first_term = (state_reg != ACCUM);
   assign last_term  = first_term ? (N_TERMS == 1)
                                  : (cnt_reg == CNT_W'(N_TERMS - 1));

   assign bias_ext = SUM_W'($signed(bias));
   assign op_ext   = SUM_W'($signed(operand));
   assign add_a    = first_term ? bias_ext : acc_reg;
   assign cnt_next = first_term ? CNT_W'(1) : cnt_reg + CNT_W'(1);
   assign sat_next = add_ovf | (~first_term & sat_acc_reg);

   neuron_acc_add #(
      .SUM_W (SUM_W)
   ) u_add (
      .a   (add_a),
      .b   (op_ext),
      .y   (add_y),
      .ovf (add_ovf)
   );

   // Accumulator FSM with registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         sat_acc_reg   <= 1'b0;
         sum_reg       <= '0;
         sat_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (clr && state_reg != DONE) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         sat_acc_reg <= 1'b0;
      end else if (in_fire) begin
         acc_reg     <= add_y;
         cnt_reg     <= cnt_next;
         sat_acc_reg <= sat_next;
         if (last_term) begin
            state_reg     <= DONE;
            sum_reg       <= add_y;
            sat_reg       <= sat_next;
            out_valid_reg <= 1'b1;
         end else begin
            state_reg     <= ACCUM;
            out_valid_reg <= 1'b0;
         end
      end else if (out_fire) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign sat       = sat_reg;

endmodule

// File: tb/tb_neuron_acc.sv
// tb_neuron_acc: directed and randomized checks of neuron_acc (N_TERMS=4 and
// N_TERMS=1 instances) against a plain-arithmetic reference model.
module tb_neuron_acc;

   localparam longint SMAX = (64'sd1 <<< 21) - 64'sd1;
   localparam longint SMIN = -(64'sd1 <<< 21);

   logic        clk;
   logic        rst;
   logic        clr;
   logic [7:0]  bias;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] operand;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] sum;
   logic        sat;

   logic        clr1;
   logic [7:0]  bias1;
   logic        in_valid1;
   logic        in_ready1;
   logic [19:0] operand1;
   logic        out_valid1;
   logic        out_ready1;
   logic [21:0] sum1;
   logic        sat1;

   int n_vec;
   int n_err;

   neuron_acc dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand   (operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .sat       (sat)
   );

   neuron_acc #(
      .N_TERMS (1)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr1),
      .bias      (bias1),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .operand   (operand1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .sat       (sat1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: bias plus every operand, clamped after each add when
   // saturation is built in, otherwise reduced modulo 2^22 at the end.
   function automatic logic [22:0] model(input longint b, input longint ops[$]);
      longint      s;
      logic        st;
      logic [63:0] u;
      s  = b;
      st = 1'b0;
      foreach (ops[i]) begin
         s = s + ops[i];
`ifdef NEURON_ACC_SAT_EN
         if (s > SMAX) begin
            s  = SMAX;
            st = 1'b1;
         end else if (s < SMIN) begin
            s  = SMIN;
            st = 1'b1;
         end
`endif
      end
      u = s;
      return {st, u[21:0]};
   endfunction

   function automatic longint sx20(input logic [19:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint sx8(input logic [7:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [19:0] rnd_op();
      logic [19:0] v;
      case ($urandom_range(3, 0))
         0:       v = 20'h7FFFF;
         1:       v = 20'h80000;
         default: v = 20'($urandom);
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Feeds four operands (random gaps up to gap_max) and checks the result.
   task automatic send_result(input logic [7:0] b, input logic [19:0] o0,
                              input logic [19:0] o1, input logic [19:0] o2,
                              input logic [19:0] o3, input int gap_max,
                              input string tag, output logic [22:0] e);
      logic [19:0] o[4];
      longint      q[$];
      o    = '{o0, o1, o2, o3};
      bias = b;
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         in_valid = 1'b1;
         operand  = o[k];
         tick();
         in_valid = 1'b0;
         operand  = 20'($urandom);
         if (k == 0) bias = 8'($urandom);
         q.push_back(sx20(o[k]));
         if (k < 3) chk({tag, "_early_ov"}, 64'(out_valid), 64'(0));
      end
      e = model(sx8(b), q);
      chk({tag, "_ov"}, 64'(out_valid), 64'(1));
      chk({tag, "_sum"}, 64'(sum), 64'(e[21:0]));
      chk({tag, "_sat"}, 64'(sat), 64'(e[22]));
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_drained"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [22:0] e;
      logic [22:0] e2;
      logic [19:0] p[4];
      logic [7:0]  b2;
      longint      q[$];

      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      clr        = 1'b0;
      bias       = '0;
      in_valid   = 1'b0;
      operand    = '0;
      out_ready  = 1'b0;
      clr1       = 1'b0;
      bias1      = '0;
      in_valid1  = 1'b0;
      operand1   = '0;
      out_ready1 = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_ov", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_sat", 64'(sat), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      tick();

      // Basic accumulation with out_ready held high
      out_ready = 1'b1;
      send_result(8'd5, 20'd1, 20'd2, 20'd3, 20'd4, 0, "basic", e);
      chk("basic_sum15", 64'(sum), 64'(15));
      tick();
      chk("basic_drained", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      // Backpressure: result held for 3 cycles, then back-to-back restart
      send_result(8'd2, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0, "bp", e);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         tick();
         chk("bp_hold_ov", 64'(out_valid), 64'(1));
         chk("bp_hold_sum", 64'(sum), 64'(e[21:0]));
         chk("bp_hold_sat", 64'(sat), 64'(e[22]));
      end
      b2 = 8'($urandom);
      for (int k = 0; k < 4; k++) p[k] = rnd_op();
      q.delete();
      bias      = b2;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         operand  = p[k];
         tick();
         q.push_back(sx20(p[k]));
         if (k < 3) chk("bp_restart_ov", 64'(out_valid), 64'(0));
      end
      in_valid = 1'b0;
      e2 = model(sx8(b2), q);
      chk("bp_new_ov", 64'(out_valid), 64'(1));
      chk("bp_new_sum", 64'(sum), 64'(e2[21:0]));
      chk("bp_new_sat", 64'(sat), 64'(e2[22]));
      tick();
      chk("bp_drained", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      // Saturation corner: largest positive operands
      send_result(8'd0, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 0, "satA", e);
      chk("satA_const", 64'(sum), 64'(22'h1FFFFC));
      drain("satA");
      send_result(8'd127, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 0, "satB", e);
      drain("satB");
      send_result(8'h80, 20'h80000, 20'h80000, 20'h80000, 20'h80000, 1, "satC", e);
      drain("satC");

      // clr after two operands, with a same-cycle operand discarded
      bias = 8'd1;
      in_valid = 1'b1;
      operand  = 20'd10;
      tick();
      operand  = 20'd20;
      tick();
      clr      = 1'b1;
      operand  = 20'd99;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("clr_ov", 64'(out_valid), 64'(0));
      chk("clr_in_ready", 64'(in_ready), 64'(1));
      send_result(8'd0, 20'd1, 20'd2, 20'd3, 20'd4, 0, "clr", e);
      chk("clr_sum10", 64'(sum), 64'(10));

      // clr while a result is pending is ignored
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_done_ov", 64'(out_valid), 64'(1));
      chk("clr_done_sum", 64'(sum), 64'(10));
      drain("clr_done");

      // Randomized results with gaps and random hold times
      for (int r = 0; r < 24; r++) begin
         send_result(8'($urandom), rnd_op(), rnd_op(), rnd_op(), rnd_op(), 2, "rnd", e);
         repeat ($urandom_range(3, 0)) begin
            tick();
            chk("rnd_hold_ov", 64'(out_valid), 64'(1));
            chk("rnd_hold_sum", 64'(sum), 64'(e[21:0]));
         end
         drain("rnd");
      end

      // Async reset in ACCUM
      send_result(8'd3, 20'd100, 20'd200, 20'd300, 20'd400, 0, "pre_rst", e);
      drain("pre_rst");
      bias     = 8'd9;
      in_valid = 1'b1;
      operand  = 20'd7;
      tick();
      tick();
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("arst_accum_sum", 64'(sum), 64'(0));
      chk("arst_accum_ov", 64'(out_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      send_result(8'hF0, 20'd5, 20'hFFFFF, 20'd12, 20'd40, 0, "post_rst1", e);
      // Async reset while a result is pending
      #3 rst = 1'b1;
      #1;
      chk("arst_done_ov", 64'(out_valid), 64'(0));
      chk("arst_done_sum", 64'(sum), 64'(0));
      chk("arst_done_sat", 64'(sat), 64'(0));
      chk("arst_done_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      tick();
      send_result(8'd50, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1, "post_rst2", e);
      drain("post_rst2");

      // N_TERMS=1: streaming result every cycle
      bias1      = 8'hFD;
      operand1   = 20'hFFFFB;
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("n1_ov", 64'(out_valid1), 64'(1));
         chk("n1_sum_m8", 64'(sum1), 64'(22'h3FFFF8));
      end
      for (int i = 0; i < 8; i++) begin
         b2 = 8'($urandom);
         p[0] = rnd_op();
         bias1    = b2;
         operand1 = p[0];
         q.delete();
         q.push_back(sx20(p[0]));
         e = model(sx8(b2), q);
         tick();
         chk("n1_rnd_ov", 64'(out_valid1), 64'(1));
         chk("n1_rnd_sum", 64'(sum1), 64'(e[21:0]));
         chk("n1_rnd_sat", 64'(sat1), 64'(e[22]));
         chk("n1_in_ready", 64'(in_ready1), 64'(1));
      end
      in_valid1 = 1'b0;
      tick();
      chk("n1_drained", 64'(out_valid1), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
